// File: rtl/key_debounce_multi.sv
// Multi-channel debouncer for active-low mechanical keys: debounced level plus
// press, release, long-press and auto-repeat pulses per channel.
module key_debounce_multi #(
  parameter int unsigned KEY_NUM      = 4,
  parameter int unsigned DEBOUNCE_MAX = 1_000_000,
  parameter int unsigned LONG_MAX     = 50_000_000,
  parameter int unsigned REPEAT_MAX   = 10_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  localparam int unsigned HOLD_MAX = (LONG_MAX > REPEAT_MAX) ? LONG_MAX : REPEAT_MAX;
  localparam int unsigned DW       = $clog2(DEBOUNCE_MAX);
  localparam int unsigned HW       = $clog2(HOLD_MAX);
  localparam logic [DW-1:0] DCNT_TOP = DW'(DEBOUNCE_MAX - 1);
  localparam logic [HW-1:0] LONG_TOP = HW'(LONG_MAX - 1);
  localparam logic [HW-1:0] REP_TOP  = (REPEAT_MAX == 0) ? '0 : HW'(REPEAT_MAX - 1);
  localparam bit            REP_EN   = (REPEAT_MAX != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_e;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic          sync1, sync2, s_q;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    hold_e         st, st_nxt;
    logic          state_q, press_q, release_q, long_q, repeat_q;
    logic          state_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;

    // Synchroniser, registered pressed level, counters, FSM and output pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync1     <= 1'b1;
        sync2     <= 1'b1;
        s_q       <= 1'b0;
        dcnt      <= '0;
        hcnt      <= '0;
        st        <= IDLE;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync1     <= key_in[i];
        sync2     <= sync1;
        s_q       <= ~sync2;
        dcnt      <= dcnt_nxt;
        hcnt      <= hcnt_nxt;
        st        <= st_nxt;
        state_q   <= state_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
        repeat_q  <= repeat_nxt;
      end
    end

    // Debounce decision and hold FSM; a release always wins over long/repeat.
    always_comb begin
      dcnt_nxt    = dcnt;
      hcnt_nxt    = hcnt;
      st_nxt      = st;
      state_nxt   = state_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      repeat_nxt  = 1'b0;

      if (s_q == state_q) begin
        dcnt_nxt = '0;
      end else if (dcnt == DCNT_TOP) begin
        dcnt_nxt    = '0;
        state_nxt   = s_q;
        press_nxt   = s_q;
        release_nxt = ~s_q;
      end else begin
        dcnt_nxt = dcnt + DW'(1);
      end

      unique case (st)
        IDLE: begin
          if (press_nxt) begin
            st_nxt   = HELD;
            hcnt_nxt = '0;
          end
        end
        HELD: begin
          if (release_nxt) begin
            st_nxt   = IDLE;
            hcnt_nxt = '0;
          end else if (hcnt == LONG_TOP) begin
            st_nxt   = LONG;
            hcnt_nxt = '0;
            long_nxt = 1'b1;
          end else begin
            hcnt_nxt = hcnt + HW'(1);
          end
        end
        LONG: begin
          if (release_nxt) begin
            st_nxt   = IDLE;
            hcnt_nxt = '0;
          end else if (REP_EN) begin
            if (hcnt == REP_TOP) begin
              hcnt_nxt   = '0;
              repeat_nxt = 1'b1;
            end else begin
              hcnt_nxt = hcnt + HW'(1);
            end
          end
        end
        default: begin
          st_nxt   = IDLE;
          hcnt_nxt = '0;
        end
      endcase
    end

    assign key_state[i]   = state_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: vector table plus hand-timed sequences.
// Latency convention: key_in changes just after an edge; pulses show D+3 steps later.
module tb_key_debounce_multi;

  localparam int unsigned N  = 4;
  localparam int unsigned DB = 20;
  localparam int unsigned LG = 100;
  localparam int unsigned RP = 30;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic [N-1:0] key_in;
  logic [N-1:0] key_state, key_press, key_release, key_long, key_repeat;
  logic [N-1:0] nr_state, nr_press, nr_release, nr_long, nr_repeat;

  int n_cmp = 0;
  int n_bad = 0;
  int press_cnt[N]   = '{default: 0};
  int release_cnt[N] = '{default: 0};
  int long_cnt[N]    = '{default: 0};
  int repeat_cnt[N]  = '{default: 0};

  key_debounce_multi #(
    .KEY_NUM(N), .DEBOUNCE_MAX(DB), .LONG_MAX(LG), .REPEAT_MAX(RP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  key_debounce_multi #(
    .KEY_NUM(N), .DEBOUNCE_MAX(DB), .LONG_MAX(LG), .REPEAT_MAX(0)
  ) dut_nr (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_state(nr_state), .key_press(nr_press), .key_release(nr_release),
    .key_long(nr_long), .key_repeat(nr_repeat)
  );

  always #10 sys_clk = ~sys_clk;

  // Pulse tallies of the main instance, sampled mid-cycle.
  always @(negedge sys_clk) begin
    for (int b = 0; b < N; b++) begin
      press_cnt[b]   += int'(key_press[b]);
      release_cnt[b] += int'(key_release[b]);
      long_cnt[b]    += int'(key_long[b]);
      repeat_cnt[b]  += int'(key_repeat[b]);
    end
  end

  typedef struct {
    logic [N-1:0] kin;
    int           cycles;
    logic [N-1:0] st, pr, rl, lg, rp;
  } vec_t;

  vec_t vt[21];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #(20 * 50000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, others;
    logic el, er, ez;

    // key0 press/long/repeat/release, 19-cycle glitch and 20-cycle minimum press on key1
    vt[0]  = '{4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[1]  = '{4'hE, 22, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[2]  = '{4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    vt[3]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[4]  = '{4'hE, 98, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[5]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
    vt[6]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[7]  = '{4'hE, 28, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[8]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
    vt[9]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[10] = '{4'hF, 22, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[11] = '{4'hF,  1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    vt[12] = '{4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[13] = '{4'hD, 19, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[14] = '{4'hF, 30, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[15] = '{4'hD, 20, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[16] = '{4'hF,  2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[17] = '{4'hF,  1, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
    vt[18] = '{4'hF, 19, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[19] = '{4'hF,  1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
    vt[20] = '{4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    sys_rst_n = 1'b0;
    key_in    = 4'hF;
    step(3);
    chk("reset_outputs", 32'({key_state, key_press, key_release, key_long, key_repeat,
                              nr_state, nr_press, nr_release, nr_long, nr_repeat}), 32'h0);
    sys_rst_n = 1'b1;

    for (int v = 0; v < 21; v++) begin
      key_in = vt[v].kin;
      step(vt[v].cycles);
      chk($sformatf("vec%0d", v),
          32'({key_state, key_press, key_release, key_long, key_repeat}),
          32'({vt[v].st, vt[v].pr, vt[v].rl, vt[v].lg, vt[v].rp}));
    end
    chk("glitch_press_count_key1", 32'(press_cnt[1]), 32'd1);
    chk("nr_state_idle", 32'(nr_state), 32'h0);

    // Bounce on key0 with runs too short to qualify, last sample high, then held low
    p0     = press_cnt[0];
    others = 0;
    for (int b = 1; b < N; b++) others += press_cnt[b] + release_cnt[b] + long_cnt[b] + repeat_cnt[b];
    for (int j = 0; j < 80; j++) begin
      key_in[0] = (j % 8 == 7) ? 1'b1 : 1'(($urandom_range(0, 1)));
      step(1);
    end
    key_in[0] = 1'b0;
    step(DB + 2);
    chk("bounce_no_early_press", 32'({key_press, 8'(press_cnt[0] - p0)}), 32'h0);
    step(1);
    chk("bounce_press", 32'({key_press, key_state}), 32'h11);
    step(5);
    chk("bounce_press_count", 32'(press_cnt[0] - p0), 32'd1);
    begin
      int o2 = 0;
      for (int b = 1; b < N; b++) o2 += press_cnt[b] + release_cnt[b] + long_cnt[b] + repeat_cnt[b];
      chk("bounce_other_bits_quiet", 32'(o2 - others), 32'd0);
    end
    key_in = 4'hF;
    step(30);

    // Long hold with repeat on key2; the no-repeat instance runs alongside
    key_in = 4'b1011;
    step(DB + 3);
    chk("hold_press", 32'({key_press, nr_press}), 32'h44);
    for (int i = 1; i <= 323; i++) begin
      step(1);
      el = (i == 100);
      er = (i > 100) && (i < 323) && ((i - 100) % 30 == 0);
      ez = (i == 323);
      chk($sformatf("hold%0d", i),
          32'({key_long[2], key_repeat[2], key_release[2], nr_long[2], nr_repeat[2], nr_release[2]}),
          32'({el, er, ez, el, 1'b0, ez}));
      if (i == 300) key_in[2] = 1'b1;
    end
    chk("hold_long_repeat_counts", 32'({8'(long_cnt[2]), 8'(repeat_cnt[2])}), 32'h0107);
    step(5);

    // Release before long on key3, then a fresh press must restart the hold count
    key_in = 4'b0111;
    step(DB + 3);
    chk("early_press", 32'(key_press), 32'h8);
    step(50);
    key_in = 4'hF;
    step(DB + 3);
    chk("early_release", 32'({key_release, key_state}), 32'h80);
    key_in = 4'b0111;
    step(DB + 3);
    chk("repress", 32'(key_press), 32'h8);
    step(LG - 1);
    chk("repress_no_long_yet", 32'({key_long, 8'(long_cnt[3])}), 32'h0);
    step(1);
    chk("repress_long", 32'(key_long), 32'h8);
    key_in = 4'hF;
    step(DB + 10);

    // All four keys together
    key_in = 4'h0;
    step(DB + 3);
    chk("simul_press", 32'({key_press, key_state}), 32'hFF);
    step(1);
    chk("simul_press_1cyc", 32'(key_press), 32'h0);
    key_in = 4'hF;
    step(DB + 3);
    chk("simul_release", 32'({key_release, key_state}), 32'hF0);
    step(1);
    chk("simul_release_1cyc", 32'(key_release), 32'h0);

    // Asynchronous reset while key0 sits in LONG
    key_in = 4'hE;
    step(DB + 3 + 110);
    chk("prereset_state", 32'({key_state, nr_state}), 32'h11);
    #4;
    sys_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({key_state, key_press, key_release, key_long, key_repeat,
                                    nr_state, nr_press, nr_release, nr_long, nr_repeat}), 32'h0);
    step(3);
    sys_rst_n = 1'b1;
    step(DB + 2);
    chk("post_reset_no_early_press", 32'({key_press, key_state}), 32'h0);
    step(1);
    chk("post_reset_press", 32'({key_press, nr_press}), 32'h11);
    key_in = 4'hF;
    step(DB + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
